// File: rtl/bfp_pkg.sv
// Shared types and constants for the block-floating-point shift controller.
package bfp_pkg;

  localparam int LANES   = 16;
  localparam int CNT_W   = 5;
  localparam int MAX_CNT = 24;

  typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;

  typedef logic [LANES-1:0][CNT_W-1:0] cnt_arr_t;

  // a - b, floored at zero (headroom minus guard bits never goes negative)
  function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/bfp_min_tree.sv
// Stage 1: clamp every lane's headroom count to MAX_CNT and register the
// minimum across the beat together with its valid.
module bfp_min_tree
  import bfp_pkg::*;
(
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  input  logic [LANES-1:0][CNT_W-1:0] in_cnt,
  output logic                        out_valid,
  output logic [CNT_W-1:0]            out_min
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CNT);

  logic [LANES-1:0][CNT_W-1:0] clamped;
  logic [CNT_W-1:0]            min_c;

  for (genvar l = 0; l < LANES; l++) begin : g_clamp
    assign clamped[l] = (in_cnt[l] > CNT_MAX) ? CNT_MAX : in_cnt[l];
  end

  // linear min reduction; starts from the clamp ceiling
  always_comb begin
    min_c = CNT_MAX;
    for (int l = 0; l < LANES; l++)
      if (clamped[l] < min_c) min_c = clamped[l];
  end

  // register the beat minimum and its valid
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_min   <= CNT_MAX;
    end else begin
      out_valid <= in_valid;
      out_min   <= min_c;
    end
  end

endmodule

// File: rtl/bfp_shift_ctrl.sv
// Block-floating-point scaling controller: frame-wide minimum headroom,
// one published shift per frame (valid/ack), cumulative block exponent.
module bfp_shift_ctrl
  import bfp_pkg::*;
#(
  parameter int FRAME_BEATS = 32,
  parameter int GUARD       = 1,
  parameter int EXP_W       = 6
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_start,
  input  logic                        i_valid,
  input  logic [LANES-1:0][CNT_W-1:0] i_cnt,
  output logic                        o_shift_valid,
  output logic [CNT_W-1:0]            o_shift,
  input  logic                        i_shift_ack,
  output logic [EXP_W-1:0]            o_exp,
  output logic                        o_busy,
  output logic                        o_ovf
);

  localparam int               BEAT_W  = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CNT);
  localparam logic [BEAT_W-1:0] LAST  = BEAT_W'(FRAME_BEATS - 1);

  state_t             state, nstate;
  logic               s1_valid;
  logic [CNT_W-1:0]   s1_min;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]   run_min;
  logic [CNT_W-1:0]   shift_q, nshift;
  logic [EXP_W-1:0]   exp_q, nexp;
  logic               ovf_q, novf;

  logic               accept;
  logic               frame_done;
  logic [CNT_W-1:0]   frame_min;
  logic [CNT_W-1:0]   frame_shift;
  logic [EXP_W+CNT_W-1:0] exp_sum;
  logic [EXP_W-1:0]   exp_sat;

  // beats outside a transform are dropped, except the one that starts it
  assign accept = i_valid && ((state != IDLE) || i_start);

  bfp_min_tree u_min_tree (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (accept),
    .in_cnt    (i_cnt),
    .out_valid (s1_valid),
    .out_min   (s1_min)
  );

  assign frame_min   = (s1_min < run_min) ? s1_min : run_min;
  // a start in this cycle flushes whatever beat sits in stage 1
  assign frame_done  = s1_valid && (beat_cnt == LAST) && !i_start;
  assign frame_shift = sat_sub(frame_min, CNT_W'(GUARD));

  assign exp_sum = {{CNT_W{1'b0}}, exp_q} + {{EXP_W{1'b0}}, shift_q};
  assign exp_sat = (|exp_sum[EXP_W+CNT_W-1:EXP_W]) ? '1 : exp_sum[EXP_W-1:0];

  // stage 2: beat counter and running minimum across the frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt <= '0;
      run_min  <= CNT_MAX;
    end else if (i_start) begin
      beat_cnt <= '0;
      run_min  <= CNT_MAX;
    end else if (s1_valid) begin
      if (beat_cnt == LAST) begin
        beat_cnt <= '0;
        run_min  <= CNT_MAX;
      end else begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
        run_min  <= frame_min;
      end
    end
  end

  // state, published shift, exponent and overflow flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      shift_q <= '0;
      exp_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= nstate;
      shift_q <= nshift;
      exp_q   <= nexp;
      ovf_q   <= novf;
    end
  end

  // next-state: publish on frame end, retire on ack, drop result if still unacked
  always_comb begin
    nstate = state;
    nshift = shift_q;
    nexp   = exp_q;
    novf   = ovf_q;
    if (i_start) begin
      nstate = ACCUM;
      nshift = '0;
      nexp   = '0;
      novf   = 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (frame_done) begin
            nstate = PUBLISH;
            nshift = frame_shift;
          end
        end
        PUBLISH: begin
          if (i_shift_ack) begin
            nexp = exp_sat;
            if (frame_done) nshift = frame_shift;
            else            nstate = ACCUM;
          end else if (frame_done) begin
            novf = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_shift_valid = (state == PUBLISH);
  assign o_shift       = shift_q;
  assign o_exp         = exp_q;
  assign o_ovf         = ovf_q;
  assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_bfp_shift_ctrl.sv
// Self-checking bench for bfp_shift_ctrl: vector table of whole frames plus
// hand sequences for overflow, same-cycle ack, saturation and mid-frame start.
module tb_bfp_shift_ctrl;
  import bfp_pkg::*;

  localparam int FB = 32;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_start, i_valid, i_shift_ack;
  cnt_arr_t   i_cnt;
  logic       o_shift_valid, o_busy, o_ovf;
  logic [CNT_W-1:0] o_shift;
  logic [5:0] o_exp;

  int n_cmp = 0;
  int n_err = 0;
  int sbq[$];

  typedef struct {
    string nm;
    int    base;
    int    sp_beat;
    int    sp_lane;
    int    sp_val;
    int    shift;
    int    exp;
  } vec_t;
  vec_t tbl[6];

  bfp_shift_ctrl #(.FRAME_BEATS(FB), .GUARD(1), .EXP_W(6)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_start       (i_start),
    .i_valid       (i_valid),
    .i_cnt         (i_cnt),
    .o_shift_valid (o_shift_valid),
    .o_shift       (o_shift),
    .i_shift_ack   (i_shift_ack),
    .o_exp         (o_exp),
    .o_busy        (o_busy),
    .o_ovf         (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic cnt_arr_t mk(input int base, input int lane, input int val);
    cnt_arr_t v;
    for (int l = 0; l < LANES; l++)
      v[l] = (l == lane) ? CNT_W'(val) : CNT_W'(base);
    return v;
  endfunction

  task automatic drive_beat(input cnt_arr_t v, input bit st);
    @(negedge clk);
    i_valid     = 1'b1;
    i_cnt       = v;
    i_start     = st;
    i_shift_ack = 1'b0;
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    i_valid     = 1'b0;
    i_start     = 1'b0;
    i_shift_ack = 1'b0;
  endtask

  task automatic frame(input int base, input int spb, input int spl,
                       input int spv, input bit st);
    for (int b = 0; b < FB; b++)
      drive_beat((b == spb) ? mk(base, spl, spv) : mk(base, -1, 0), st && (b == 0));
  endtask

  // compare the held shift against the scoreboard head, then ack it
  task automatic do_ack(input string nm);
    int e;
    chk({nm, "_valid"}, int'(o_shift_valid), 1);
    if (sbq.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_sb: got shift %0d, want none queued", nm, o_shift);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_shift"}, int'(o_shift), e);
    end
    i_shift_ack = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_cnt = '0; i_shift_ack = 1'b0;

    tbl[0] = '{"one_low_lane", 10,  5,  3,  4,  3,  3};
    tbl[1] = '{"clamp31",      31, -1,  0,  0, 23, 26};
    tbl[2] = '{"zero_lane",    10,  0,  7,  0,  0, 26};
    tbl[3] = '{"one_lane",     20, 31, 15,  1,  0, 26};
    tbl[4] = '{"clamp_lane",   12, 31,  0, 25, 11, 37};
    tbl[5] = '{"guard_edge",    2, -1,  0,  0,  1, 38};

    repeat (3) @(negedge clk);
    chk("rst_valid", int'(o_shift_valid), 0);
    chk("rst_shift", int'(o_shift), 0);
    chk("rst_exp",   int'(o_exp), 0);
    chk("rst_ovf",   int'(o_ovf), 0);
    chk("rst_busy",  int'(o_busy), 0);
    rstn = 1'b1;

    // beats in IDLE without a start must be ignored
    for (int i = 0; i < FB + 8; i++) drive_beat(mk(0, -1, 0), 1'b0);
    repeat (3) idle_cyc();
    chk("idle_valid", int'(o_shift_valid), 0);
    chk("idle_busy",  int'(o_busy), 0);

    // table of whole frames, each acked after publication
    for (int i = 0; i < 6; i++) begin
      frame(tbl[i].base, tbl[i].sp_beat, tbl[i].sp_lane, tbl[i].sp_val, i == 0);
      sbq.push_back(tbl[i].shift);
      idle_cyc();
      chk({tbl[i].nm, "_t1"}, int'(o_shift_valid), 0);
      chk({tbl[i].nm, "_busy"}, int'(o_busy), 1);
      idle_cyc();
      do_ack(tbl[i].nm);
      idle_cyc();
      chk({tbl[i].nm, "_exp"}, int'(o_exp), tbl[i].exp);
      chk({tbl[i].nm, "_done"}, int'(o_shift_valid), 0);
    end

    // ack with nothing published changes nothing
    i_shift_ack = 1'b1;
    idle_cyc();
    idle_cyc();
    chk("stray_ack_exp", int'(o_exp), 38);

    // ack in the same cycle a new frame result lands
    frame(8, -1, 0, 0, 1'b1);
    sbq.push_back(7);
    idle_cyc();
    idle_cyc();
    chk("c_pub", int'(o_shift_valid), 1);
    frame(9, -1, 0, 0, 1'b0);
    sbq.push_back(8);
    idle_cyc();
    do_ack("same_cyc");
    idle_cyc();
    chk("same_cyc_valid", int'(o_shift_valid), 1);
    chk("same_cyc_ovf",   int'(o_ovf), 0);
    chk("same_cyc_exp",   int'(o_exp), 7);
    chk("same_cyc_shift", int'(o_shift), 8);

    // unacked frame end: result dropped, shift held, ovf sticky
    frame(5, -1, 0, 0, 1'b0);
    idle_cyc();
    idle_cyc();
    chk("ovf_set",   int'(o_ovf), 1);
    chk("ovf_held",  int'(o_shift), 8);
    do_ack("ovf");
    idle_cyc();
    chk("ovf_exp",   int'(o_exp), 15);
    chk("ovf_clear_valid", int'(o_shift_valid), 0);

    // exponent saturation: 23 * 3 = 69 -> 63
    begin
      int sat_exp[3];
      sat_exp = '{23, 46, 63};
      for (int k = 0; k < 3; k++) begin
        frame(31, -1, 0, 0, k == 0);
        sbq.push_back(23);
        idle_cyc();
        idle_cyc();
        do_ack("sat");
        idle_cyc();
        chk("sat_exp", int'(o_exp), sat_exp[k]);
      end
    end

    // build up a pending publish plus ovf, then restart mid-frame
    frame(6, -1, 0, 0, 1'b0);
    frame(7, -1, 0, 0, 1'b0);
    idle_cyc();
    idle_cyc();
    chk("pre_start_ovf", int'(o_ovf), 1);
    for (int b = 0; b < 17; b++) drive_beat(mk(3, -1, 0), 1'b0);
    drive_beat(mk(20, -1, 0), 1'b1);
    drive_beat(mk(20, -1, 0), 1'b0);
    chk("start_exp",   int'(o_exp), 0);
    chk("start_ovf",   int'(o_ovf), 0);
    chk("start_valid", int'(o_shift_valid), 0);
    for (int b = 2; b < 31; b++) drive_beat(mk(20, -1, 0), 1'b0);
    chk("no_early_end", int'(o_shift_valid), 0);
    drive_beat(mk(20, -1, 0), 1'b0);
    sbq.push_back(19);
    idle_cyc();
    chk("restart_t1", int'(o_shift_valid), 0);
    idle_cyc();
    do_ack("restart");
    idle_cyc();
    chk("restart_exp", int'(o_exp), 19);

    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
